pc_sequencer: RTL

// - Owns the program counter and sequences next-PC selection for the fetch stage: sequential PC+4,

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter owner for the fetch stage: picks the next PC from PC+4, an execute-stage
// redirect or the trap vector. Adds a one-cycle flush bubble after redirects and halts on misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC    = 32'h0000_0100,
  parameter logic [31:0] ALIGN_MASK = 32'h0000_0003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        br_ready,
  input  logic        trap_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic        misalign_err_next;
  logic [31:0] err_addr_next;
  logic [31:0] seq_pc;
  logic        misaligned;

  assign pc_plus4   = pc + 32'd4;
  assign seq_pc     = stall ? pc : pc_plus4;
  assign misaligned = |(br_target & ALIGN_MASK);

  // All handshake/status outputs are decoded from state only.
  assign fetch_valid = (state == RUN) || (state == FLUSH);
  assign flush       = (state == FLUSH);
  assign br_ready    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      err_addr     <= 32'h0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      misalign_err <= misalign_err_next;
      err_addr     <= err_addr_next;
    end
  end

  always_comb begin
    state_next        = state;
    pc_next           = pc;
    misalign_err_next = misalign_err;
    err_addr_next     = err_addr;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (trap_req) begin
          pc_next    = TRAP_PC;
          state_next = FLUSH;
        end else if (br_valid && br_taken && !misaligned) begin
          pc_next    = br_target;
          state_next = FLUSH;
        end else if (br_valid && br_taken) begin
          misalign_err_next = 1'b1;
          err_addr_next     = br_target;
          state_next        = HALT;
        end else begin
          pc_next = seq_pc;
        end
      end
      FLUSH: begin
        // Branches are not accepted here; only a trap can redirect again.
        if (trap_req) begin
          pc_next    = TRAP_PC;
          state_next = FLUSH;
        end else begin
          pc_next    = seq_pc;
          state_next = RUN;
        end
      end
      HALT: begin
        if (resume) begin
          pc_next           = TRAP_PC;
          misalign_err_next = 1'b0;
          state_next        = FLUSH;
        end
      end
      default: state_next = BOOT;
    endcase
  end

endmodule
